// File: rtl/onehot_enc_pkg.sv
// Shared constants and code-mapping helpers for the one-hot request encoder.
// Line i of the one-hot bus maps to code i+1; code 0 means idle. This mapping
// matches the code-to-one-hot select decoder in the matrix multiplier datapath.
package onehot_enc_pkg;

  localparam int unsigned N_LINES_DEF = 13;
  localparam int unsigned CODE_W_DEF  = 4;
  localparam int unsigned CODE_IDLE   = 0;

  function automatic int unsigned line_to_code(input int unsigned i);
    return i + 1;
  endfunction

  function automatic int unsigned code_to_line(input int unsigned c);
    return c - 1;
  endfunction

endpackage

// File: rtl/onehot_rr_picker.sv
// Combinational picker: finds the first set bit of cand_i, searching upward from
// start_i and wrapping at N_LINES-1.
// Ports:
//   cand_i   candidate line vector
//   start_i  first index searched (0 gives fixed lowest-index priority)
//   found_o  at least one candidate is set
//   idx_o    index of the chosen candidate (0 when none)
module onehot_rr_picker #(
  parameter int unsigned N_LINES = 13,
  parameter int unsigned IDX_W   = 4
) (
  input  logic [N_LINES-1:0] cand_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the farthest offset down to offset 0 so the nearest hit to
  // start_i is the last assignment and therefore wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int off = N_LINES - 1; off >= 0; off--) begin
      j = (int'(start_i) + off) % N_LINES;
      if (cand_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/onehot_req_encoder.sv
// One-hot request encoder: collects strobes from N_LINES one-hot lines as sticky
// pending flags and issues them one at a time as codes (line i -> code i+1)
// over a valid/ready handshake.
// Build option: define ONEHOT_ENC_RR_EN for round-robin selection; otherwise
// fixed priority, lowest index first, with no pointer register.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_in      request strobes, any number hot per cycle
//   code_out    encoded line (i+1), 0 whenever code_valid is low
//   code_valid  code_out holds a valid code
//   code_ready  consumer accepts code_out this cycle
//   pending     sticky requests not yet issued
//   busy        code_valid or any pending
// N_LINES must not exceed 2**CODE_W - 1.
module onehot_req_encoder
  import onehot_enc_pkg::*;
#(
  parameter int unsigned N_LINES = N_LINES_DEF,
  parameter int unsigned CODE_W  = CODE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] req_in,
  output logic [CODE_W-1:0]  code_out,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [N_LINES-1:0] pending,
  output logic               busy
);

  localparam int unsigned IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;

  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic [N_LINES-1:0] cand;
  logic [N_LINES-1:0] issue_mask;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   idx;
  logic               found;
  logic               slot_free;
  logic               issue;

`ifdef ONEHOT_ENC_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search starts just after the last issued line.
  assign start = (ptr_q == IDX_W'(N_LINES - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_d = issue ? idx : ptr_q;
`else
  assign start = '0;
`endif

  assign cand = pending_q | req_in;

  onehot_rr_picker #(
    .N_LINES(N_LINES),
    .IDX_W  (IDX_W)
  ) u_picker (
    .cand_i (cand),
    .start_i(start),
    .found_o(found),
    .idx_o  (idx)
  );

  always_comb begin
    slot_free  = !valid_q || code_ready;
    issue      = slot_free && found;
    issue_mask = '0;
    if (issue) begin
      issue_mask[idx] = 1'b1;
    end
    // The issued line is cleared. If it was already pending, a same-cycle
    // strobe on it is a fresh request and survives; if it was not pending,
    // the strobe itself is what got issued and must not linger.
    pending_d = (pending_q & ~issue_mask) | (req_in & ~(issue_mask & ~pending_q));

    valid_d = valid_q;
    code_d  = code_q;
    if (slot_free) begin
      valid_d = found;
      code_d  = found ? CODE_W'(line_to_code(int'(idx))) : CODE_W'(CODE_IDLE);
    end
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      code_q  <= CODE_W'(CODE_IDLE);
`ifdef ONEHOT_ENC_RR_EN
      ptr_q   <= IDX_W'(N_LINES - 1);
`endif
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
`ifdef ONEHOT_ENC_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Sticky pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign pending    = pending_q;
  assign busy       = valid_q | (|pending_q);

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Self-checking bench for onehot_req_encoder: a directed vector table, a
// round-robin/fixed-priority sequence, and a randomized run against a model.
module tb_onehot_req_encoder;
  import onehot_enc_pkg::*;

  localparam int N = 13;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_in;
  logic [3:0]    code_out;
  logic          code_valid;
  logic          code_ready;
  logic [N-1:0]  pending;
  logic          busy;

  int n_tests;
  int n_fail;

  onehot_req_encoder #(
    .N_LINES(N),
    .CODE_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .pending   (pending),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic         rdy;
    logic         ev;
    logic [3:0]   ec;
    logic [N-1:0] ep;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state: output slot plus per-line pending flags.
  bit m_valid;
  int m_line;
  bit m_pend[N];
  int m_last;

  task automatic add_vec(input logic r, input logic [N-1:0] q, input logic y,
                         input logic v, input logic [3:0] c, input logic [N-1:0] p);
    vec_t e;
    e = '{r: r, req: q, rdy: y, ev: v, ec: c, ep: p};
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (line %0d) expected %0d", name, got,
               int'(code_to_line(got)), exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] q, input logic y);
    rst        = r;
    req_in     = q;
    code_ready = y;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit r, input logic [N-1:0] q, input bit y);
    int k;
    int start;
    int j;
    bit cand[N];
    if (r) begin
      m_valid = 0;
      m_line  = -1;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      return;
    end
    for (int i = 0; i < N; i++) cand[i] = m_pend[i] || q[i];
    k = -1;
    if (!m_valid || y) begin
`ifdef ONEHOT_ENC_RR_EN
      start = (m_last + 1) % N;
`else
      start = 0;
`endif
      for (int off = 0; off < N; off++) begin
        j = (start + off) % N;
        if (k < 0 && cand[j]) k = j;
      end
      m_valid = (k >= 0);
      m_line  = k;
      if (k >= 0) m_last = k;
    end
    for (int i = 0; i < N; i++) begin
      if (i == k) m_pend[i] = m_pend[i] ? q[i] : 1'b0;
      else        m_pend[i] = m_pend[i] || q[i];
    end
  endtask

  function automatic logic [N-1:0] model_pend_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  logic [3:0] rr_drain[3];
  int         rr_pat[6];

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_in     = '0;
    code_ready = 1'b0;

    // Reset with all lines requesting, then idle.
    add_vec(1, 13'h1FFF, 0, 0, 0, 13'h0);
    add_vec(1, 13'h1FFF, 0, 0, 0, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    // Single strobe on line 2.
    add_vec(0, 13'h0004, 1, 1, 3, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    // Burst on lines 0, 4, 12.
    add_vec(1, 13'h0000, 1, 0, 0, 13'h0);
    add_vec(0, 13'h1011, 1, 1, 1, 13'h1010);
    add_vec(0, 13'h0000, 1, 1, 5, 13'h1000);
    add_vec(0, 13'h0000, 1, 1, 13, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    // Backpressure with a merged repeat on line 2.
    add_vec(1, 13'h0000, 0, 0, 0, 13'h0);
    add_vec(0, 13'h0006, 0, 1, 2, 13'h0004);
    add_vec(0, 13'h0000, 0, 1, 2, 13'h0004);
    add_vec(0, 13'h0004, 0, 1, 2, 13'h0004);
    add_vec(0, 13'h0000, 1, 1, 3, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    // ready while idle is ignored
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    // Reset mid-handshake with pending = 0x0F0.
    add_vec(1, 13'h0000, 0, 0, 0, 13'h0);
    add_vec(0, 13'h00F0, 0, 1, 5, 13'h00E0);
    add_vec(0, 13'h0010, 0, 1, 5, 13'h00F0);
    add_vec(1, 13'h0000, 0, 0, 0, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);
    add_vec(0, 13'h0000, 1, 0, 0, 13'h0);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].req, vecs[i].rdy);
      check($sformatf("vec%0d valid", i), int'(code_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d code", i), int'(code_out), int'(vecs[i].ec));
      check($sformatf("vec%0d pending", i), int'(pending), int'(vecs[i].ep));
      check($sformatf("vec%0d busy", i), int'(busy),
            int'(vecs[i].ev | (|vecs[i].ep)));
    end

    // Lines 0 and 1 requested continuously, then drained.
`ifdef ONEHOT_ENC_RR_EN
    rr_pat   = '{1, 2, 1, 2, 1, 2};
    rr_drain = '{4'd1, 4'd2, 4'd0};
`else
    rr_pat   = '{1, 1, 1, 1, 1, 1};
    rr_drain = '{4'd2, 4'd0, 4'd0};
`endif
    cycle(1, 13'h0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 13'h0003, 1);
      check($sformatf("arb%0d code", i), int'(code_out), rr_pat[i]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 13'h0000, 1);
      check($sformatf("drain%0d code", i), int'(code_out), int'(rr_drain[i]));
    end

    // Randomized run against the model.
    model_step(1, '0, 0);
    cycle(1, 13'h0, 0);
    for (int t = 0; t < 3000; t++) begin
      logic         r;
      logic [N-1:0] q;
      logic         y;
      r = ($urandom_range(0, 99) < 2);
      q = N'($urandom & $urandom & $urandom);
      y = ($urandom_range(0, 99) < 65);
      model_step(r, q, y);
      cycle(r, q, y);
      check($sformatf("rnd%0d valid", t), int'(code_valid), int'(m_valid));
      check($sformatf("rnd%0d code", t), int'(code_out), m_valid ? m_line + 1 : 0);
      check($sformatf("rnd%0d pending", t), int'(pending), int'(model_pend_vec()));
      check($sformatf("rnd%0d busy", t), int'(busy),
            int'(m_valid || (|model_pend_vec())));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
